alu_op_sequencer: RTL and testbench

- Front-end controller for the lab ALU/display top.
- Replaces the separate button clocks (operand A, operand B, opcode) with one-clock, edge-detected strobes.
- Enforces the load order A -> B -> OP, then launches the ALU and waits a fixed latency.
- Captures the result and flags, and drives the value the 7-segment driver shows.

---
 rtl/alu_op_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: front-end controller for the lab ALU/display top.
// Conditions three raw button levels into single-cycle edges, enforces the
// load order A -> B -> OP, launches the ALU, waits ALU_LAT cycles, captures
// the result and flags, and drives the 7-segment display value.
// Optional feature: define ALU_SEQ_CHAIN_EN so that a B press in DONE chains
// the previous result into operand A (accumulator style).
module alu_op_sequencer #(
    parameter int WIDTH   = 32,
    parameter int OP_W    = 4,
    parameter int FLAG_W  = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  sw,
    input  logic              btn_a,
    input  logic              btn_b,
    input  logic              btn_op,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_start,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags,
    output logic              result_valid,
    output logic              seq_err,
    output logic [2:0]        state,
    output logic [WIDTH-1:0]  disp_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GOT_A = 3'd1,
        GOT_B = 3'd2,
        EXEC  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Counter value at which the capture edge is reached (1st edge counts as 0).
    localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

    // Button chains: bit0 = s1, bit1 = s2, bit2 = s3.
    logic [2:0] a_sync_q, b_sync_q, op_sync_q;
    logic [2:0] a_sync_d, b_sync_d, op_sync_d;
    logic       edge_a, edge_b, edge_op;
    logic       win_a, win_b, win_op;

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic [WIDTH-1:0]  alu_a_q, alu_b_q, result_q, disp_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [FLAG_W-1:0] flags_q;
    logic              alu_start_q, result_valid_q, seq_err_q;

    // Shift each raw button into its chain, detect rising edges, resolve priority a > b > op.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        a_sync_d  = {a_sync_q[1:0], btn_a};
        b_sync_d  = {b_sync_q[1:0], btn_b};
        op_sync_d = {op_sync_q[1:0], btn_op};
        edge_a    = a_sync_q[1] & ~a_sync_q[2];
        edge_b    = b_sync_q[1] & ~b_sync_q[2];
        edge_op   = op_sync_q[1] & ~op_sync_q[2];
        win_a     = edge_a;
        win_b     = edge_b & ~edge_a;
        win_op    = edge_op & ~edge_a & ~edge_b;
    end

    // Button synchronizer/edge-detect flops.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
        if (rst) begin
            a_sync_q  <= '0;
            b_sync_q  <= '0;
            op_sync_q <= '0;
        end else begin
            a_sync_q  <= a_sync_d;
            b_sync_q  <= b_sync_d;
            op_sync_q <= op_sync_d;
        end
    end

    // Sequencer FSM with registered outputs; loads, launch, latency count and capture.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and clears every register, including operands and result.
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_op_q       <= '0;
            result_q       <= '0;
            flags_q        <= '0;
            disp_q         <= '0;
            alu_start_q    <= 1'b0;
            result_valid_q <= 1'b0;
            seq_err_q      <= 1'b0;
        end else begin
            // Pulses default low; branches raise them for exactly one cycle.
            alu_start_q <= 1'b0;
            seq_err_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (win_a) begin
                        alu_a_q <= sw;
                        disp_q  <= sw;
                        state_q <= GOT_A;
                    end else if (win_b || win_op) begin
                        seq_err_q <= 1'b1;
                    end
                end
                GOT_A: begin
                    if (win_a) begin
                        alu_a_q <= sw;
                        disp_q  <= sw;
                    end else if (win_b) begin
                        alu_b_q <= sw;
                        disp_q  <= sw;
                        state_q <= GOT_B;
                    end else if (win_op) begin
                        seq_err_q <= 1'b1;
                    end
                end
                GOT_B: begin
                    if (win_a) begin
                        alu_a_q <= sw;
                        disp_q  <= sw;
                        state_q <= GOT_A;
                    end else if (win_b) begin
                        alu_b_q <= sw;
                        disp_q  <= sw;
                    end else if (win_op) begin
                        alu_op_q    <= sw[OP_W-1:0];
                        alu_start_q <= 1'b1;
                        cnt_q       <= '0;
                        disp_q      <= result_q;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    // Button edges are dropped here without an error.
                    if (cnt_q == LAT_LAST) begin
                        result_q       <= alu_result;
                        flags_q        <= alu_flags;
                        disp_q         <= alu_result;
                        result_valid_q <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    if (win_a) begin
                        alu_a_q        <= sw;
                        disp_q         <= sw;
                        result_valid_q <= 1'b0;
                        state_q        <= GOT_A;
                    end else if (win_b) begin
`ifdef ALU_SEQ_CHAIN_EN
                        alu_a_q        <= result_q;
                        alu_b_q        <= sw;
                        disp_q         <= sw;
                        result_valid_q <= 1'b0;
                        state_q        <= GOT_B;
`else
                        seq_err_q <= 1'b1;
`endif
                    end else if (win_op) begin
                        alu_op_q       <= sw[OP_W-1:0];
                        alu_start_q    <= 1'b1;
                        cnt_q          <= '0;
                        result_valid_q <= 1'b0;
                        state_q        <= EXEC;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign alu_start    = alu_start_q;
    assign result       = result_q;
    assign flags        = flags_q;
    assign result_valid = result_valid_q;
    assign seq_err      = seq_err_q;
    assign state        = state_q;
    assign disp_data    = disp_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a small add/sub ALU model
// (ALU_LAT = 2, flags = {Z,C,V,N}, C = carry-out on add / borrow on sub).
module tb_alu_op_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  sw;
    logic          btn_a, btn_b, btn_op;
    logic [W-1:0]  alu_a, alu_b, alu_result, result, disp_data;
    logic [3:0]    alu_op, alu_flags, flags;
    logic          alu_start, result_valid, seq_err;
    logic [2:0]    state;

    int test_cnt = 0;
    int fail_cnt = 0;
    int start_pulses = 0;
    int err_pulses = 0;
    int mark;

    alu_op_sequencer #(.WIDTH(W), .OP_W(4), .FLAG_W(4), .ALU_LAT(2)) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .btn_a(btn_a), .btn_b(btn_b), .btn_op(btn_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .result(result), .flags(flags), .result_valid(result_valid),
        .seq_err(seq_err), .state(state), .disp_data(disp_data)
    );

    always #5 clk = ~clk;

    // ALU model: operands are held stable by the sequencer, so a combinational model suffices.
    always_comb begin
        logic [W:0] wide;
        wide       = '0;
        alu_result = '0;
        alu_flags  = '0;
        if (alu_op == 4'h0) begin
            wide       = {1'b0, alu_a} + {1'b0, alu_b};
            alu_result = wide[W-1:0];
            alu_flags  = {alu_result == '0, wide[W],
                          (alu_a[W-1] == alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]),
                          alu_result[W-1]};
        end else if (alu_op == 4'h1) begin
            alu_result = alu_a - alu_b;
            alu_flags  = {alu_result == '0, alu_a < alu_b,
                          (alu_a[W-1] != alu_b[W-1]) && (alu_result[W-1] != alu_a[W-1]),
                          alu_result[W-1]};
        end
    end

    // Pulse monitors, sampled away from the active edge.
    always @(negedge clk) begin
        if (alu_start) start_pulses++;
        if (seq_err)   err_pulses++;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press mask {op,b,a} with switch value; returns on the negedge right after the load edge.
    task automatic press(input logic [2:0] mask, input logic [W-1:0] val);
        tick(3);
        sw     = val;
        btn_a  = mask[0];
        btn_b  = mask[1];
        btn_op = mask[2];
        tick(3);
        btn_a  = 1'b0;
        btn_b  = 1'b0;
        btn_op = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sw = '0; btn_a = 1'b0; btn_b = 1'b0; btn_op = 1'b0;
        tick(3);
        rst = 1'b0;

        // Reset state
        check("rst_state", W'(state), 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_result", result, 0);
        check("rst_valid", W'(result_valid), 0);
        check("rst_disp", disp_data, 0);
        check("rst_start", W'(alu_start), 0);

        // B from IDLE is out of order
        press(3'b010, 32'd9);
        check("idle_b_err", W'(seq_err), 1);
        check("idle_b_state", W'(state), 0);
        check("idle_b_alu_b", alu_b, 0);
        tick(1);
        check("idle_b_err_pulse", W'(seq_err), 0);

        // A then OP: OP out of order in GOT_A
        press(3'b001, 32'd5);
        check("a_state", W'(state), 1);
        check("a_disp", disp_data, 5);
        press(3'b100, 32'd0);
        check("gota_op_err", W'(seq_err), 1);
        check("gota_op_state", W'(state), 1);
        tick(1);
        check("gota_op_err_pulse", W'(seq_err), 0);

        // Held A: one load only
        mark = err_pulses;
        tick(3);
        sw = 32'd6; btn_a = 1'b1;
        tick(3);
        check("held_first_load", alu_a, 6);
        sw = 32'd7;
        tick(47);
        check("held_single_load", alu_a, 6);
        check("held_state", W'(state), 1);
        btn_a = 1'b0;

        // A and B together from GOT_A: A wins, B discarded silently
        press(3'b011, 32'd11);
        check("simul_alu_a", alu_a, 11);
        check("simul_alu_b", alu_b, 0);
        check("simul_state", W'(state), 1);
        tick(1);
        check("simul_no_err", W'(err_pulses - mark), 0);

        // Basic 5 + 3
        press(3'b001, 32'd5);
        press(3'b010, 32'd3);
        check("b_state", W'(state), 2);
        check("b_alu_b", alu_b, 3);
        check("b_disp", disp_data, 3);
        mark = start_pulses;
        press(3'b100, 32'd0);
        check("exec_state", W'(state), 3);
        check("exec_start", W'(alu_start), 1);
        check("exec_disp_prev", disp_data, 0);
        tick(1);
        check("exec_start_drop", W'(alu_start), 0);
        check("exec_wait_state", W'(state), 3);
        check("exec_wait_valid", W'(result_valid), 0);
        tick(1);
        check("done_state", W'(state), 4);
        check("done_result", result, 8);
        check("done_flags", W'(flags), 0);
        check("done_valid", W'(result_valid), 1);
        check("done_disp", disp_data, 8);
        check("one_start_pulse", W'(start_pulses - mark), 1);

        // B in DONE: chain or error depending on build
        press(3'b010, 32'd2);
`ifdef ALU_SEQ_CHAIN_EN
        check("chain_state", W'(state), 2);
        check("chain_alu_a", alu_a, 8);
        check("chain_alu_b", alu_b, 2);
        press(3'b100, 32'd1);
        tick(2);
        check("chain_result", result, 6);
        check("chain_done", W'(state), 4);
`else
        check("done_b_err", W'(seq_err), 1);
        check("done_b_state", W'(state), 4);
        check("done_b_result", result, 8);
        check("done_b_valid", W'(result_valid), 1);
`endif

        // 5 + 5, then re-execute as 5 - 5 with an A press arriving during EXEC
        press(3'b001, 32'd5);
        check("redo_a_valid", W'(result_valid), 0);
        press(3'b010, 32'd5);
        press(3'b100, 32'd0);
        tick(2);
        check("add55_result", result, 10);
        mark = err_pulses;
        tick(3);
        sw = 32'd1; btn_op = 1'b1;
        tick(1);
        btn_a = 1'b1;
        tick(2);
        btn_op = 1'b0;
        check("reexec_state", W'(state), 3);
        check("reexec_disp_prev", disp_data, 10);
        tick(1);
        check("exec_ignores_a", alu_a, 5);
        tick(1);
        btn_a = 1'b0;
        check("sub_result", result, 0);
        check("sub_flags_z", W'(flags), 32'h8);
        check("sub_state", W'(state), 4);
        check("exec_no_err", W'(err_pulses - mark), 0);
        press(3'b001, 32'd7);
        check("after_done_state", W'(state), 1);
        check("after_done_valid", W'(result_valid), 0);
        check("after_done_disp", disp_data, 7);

        // Signed overflow on add: 0x7FFFFFFF + 1
        press(3'b001, 32'h7FFF_FFFF);
        press(3'b010, 32'd1);
        press(3'b100, 32'd0);
        tick(2);
        check("ovf_result", result, 32'h8000_0000);
        check("ovf_flags", W'(flags), 32'h3);

        // Reset in the cycle after alu_start aborts the capture
        press(3'b100, 32'd1);
        check("mid_start", W'(alu_start), 1);
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_state", W'(state), 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_flags", W'(flags), 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_b", alu_b, 0);
        check("mid_rst_alu_op", W'(alu_op), 0);
        check("mid_rst_disp", disp_data, 0);
        check("mid_rst_start", W'(alu_start), 0);
        tick(4);
        check("no_late_capture", result, 0);
        check("no_late_valid", W'(result_valid), 0);
        check("no_late_state", W'(state), 0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
